// File: rtl/edge_pkg.sv
// Shared types for the debounced edge detector bank: per-channel FSM states
// and the global pulse-select encoding.
package edge_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        ARM_HIGH = 2'b01,
        HIGH     = 2'b10,
        ARM_LOW  = 2'b11
    } edge_state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_t;

endpackage

// File: rtl/edge_channel.sv
// One debounced channel: optional synchroniser, arm/confirm FSM with a
// stability counter, and registered rise/fall pulses plus the clean level.
module edge_channel
    import edge_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int            CW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST   = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam bit            DIRECT = (STABLE_CYCLES == 1);

    edge_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end

            assign s = sr[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = in;
        end
    endgenerate

    // The first differing sample counts as 1; a full run of STABLE_CYCLES flips the level.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rise_next = 1'b0;
        fall_next = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    if (DIRECT) begin
                        state_n   = HIGH;
                        rise_next = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        state_n = ARM_HIGH;
                        cnt_n   = ONE;
                    end
                end
            end
            ARM_HIGH: begin
                if (!s) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n   = HIGH;
                    rise_next = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (DIRECT) begin
                        state_n   = LOW;
                        fall_next = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        state_n = ARM_LOW;
                        cnt_n   = ONE;
                    end
                end
            end
            ARM_LOW: begin
                if (s) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n   = LOW;
                    fall_next = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= (state_n == HIGH) || (state_n == ARM_LOW);
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/edge_detector_bank.sv
// N independent debounced channels with a shared pulse-select mode, per-channel
// sticky event flags and an OR-reduced any_event for polling logic.
module edge_detector_bank
    import edge_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic [1:0]   mode,
    input  logic [N-1:0] clear,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] pulse,
    output logic [N-1:0] event_sticky,
    output logic         any_event
);

    logic [N-1:0] rise_next, fall_next, pulse_next;
    edge_mode_t   sel;
    logic         rise_en, fall_en;

    generate
        for (genvar g = 0; g < N; g++) begin : g_ch
            edge_channel #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .SYNC_STAGES  (SYNC_STAGES)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .in       (in[g]),
                .level    (level[g]),
                .rise     (rise[g]),
                .fall     (fall[g]),
                .rise_next(rise_next[g]),
                .fall_next(fall_next[g])
            );
        end
    endgenerate

    // Gating uses the pre-edge transition so mode is sampled on the same edge as rise/fall.
    assign sel        = edge_mode_t'(mode);
    assign rise_en    = (sel == RISE) || (sel == BOTH);
    assign fall_en    = (sel == FALL) || (sel == BOTH);
    assign pulse_next = (rise_next & {N{rise_en}}) | (fall_next & {N{fall_en}});

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse        <= '0;
            event_sticky <= '0;
        end else begin
            pulse        <= pulse_next;
            event_sticky <= pulse_next | (event_sticky & ~clear);
        end
    end

    assign any_event = |event_sticky;

endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Multi-channel, debounced edge detector for buttons, encoder pins and other slow external inputs. Each channel optionally synchronises its raw input, filters glitches shorter than a programmable number of cycles, and produces single-cycle rise/fall pulses, a clean level, and a sticky event flag for polling logic. It sits between board I/O and the UI/control FSMs, replacing single-channel, non-filtered edge detection.

## Interface
- `N`, 4: number of independent channels (≥1).
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a level change (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel ahead of the filter (0–3; 0 means input already synchronous).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in`  in  N  raw channel inputs.
- `mode`  in  2  global pulse select: 00 none, 01 rising, 10 falling, 11 both.
- `clear`  in  N  per-channel clear of `event_sticky`.
- `level`  out  N  debounced level.
- `rise`  out  N  one-cycle pulse on an accepted 0→1 change.
- `fall`  out  N  one-cycle pulse on an accepted 1→0 change.
- `pulse`  out  N  `rise`/`fall` gated by `mode`.
- `event_sticky`  out  N  latched `pulse`, held until `clear`.
- `any_event`  out  1  OR-reduction of `event_sticky`.

## Operation
- Per-channel FSM, states LOW, ARM_HIGH, HIGH, ARM_LOW; counter width $clog2(STABLE_CYCLES+1).
- LOW: sample s=1 → ARM_HIGH, cnt=1 (STABLE_CYCLES=1: straight to HIGH). s=0 → stay.
- ARM_HIGH: s=0 → LOW, cnt=0 (glitch rejected, no pulse). s=1 and cnt==STABLE_CYCLES-1 → HIGH, assert `rise`. Else cnt+1.
- HIGH/ARM_LOW: mirror image with s inverted, asserting `fall` on entry to LOW.
- `level`=1 exactly in HIGH and ARM_LOW.
- `pulse[i]` = (`rise[i]` & mode[0]) | (`fall[i]` & mode[1]), using `mode` sampled on the same edge as the transition.
- `event_sticky[i]` sets on `pulse[i]`; `clear[i]` zeroes it; set and clear on the same edge → set wins.
- Channels are fully independent; simultaneous events on any set of channels all reported in the same cycle.
- Mode change only affects transitions from the next edge onward; no retroactive pulses.

## Timing
- Reset: all FSMs LOW, counters 0, synchroniser flops 0; `level`, `rise`, `fall`, `pulse`, `event_sticky`, `any_event` all 0 the cycle after the reset edge.
- Input high through reset release is treated as a fresh rising edge after the normal latency.
- All outputs registered; no combinational path from `in`, `mode` or `clear` to outputs except `any_event` (OR of registers).
- Latency: `in` stable from edge t → `level`/`rise` change after edge t+SYNC_STAGES+STABLE_CYCLES-1; `rise`/`fall` high exactly one cycle.
- Minimum accepted pulse width STABLE_CYCLES cycles; any shorter excursion produces no output.
- Reset asserted mid-arm or mid-pulse: aborts immediately, no pulse emitted afterward.

## Structure
- Package `edge_pkg`: `edge_state_t` enum (LOW, ARM_HIGH, HIGH, ARM_LOW), `edge_mode_t` enum (NONE, RISE, FALL, BOTH).
- Sub-module `edge_channel`: synchroniser, FSM, counter, rise/fall registers for one channel; top instantiates N via generate and holds the `mode` gating, sticky flags and `any_event`.

## Test plan
- Reset with all inputs high, STABLE_CYCLES=4, SYNC_STAGES=2 → all outputs 0; `rise` pulses once after 5 further cycles, `level`=1 thereafter.
- 3-cycle high glitch on channel 0, STABLE_CYCLES=4 → no `rise`, `level` stays 0, FSM returns to LOW.
- mode=10, clean high then low on channel 1 → `rise` and `fall` each pulse once, `pulse` only on the fall, `event_sticky[1]`=1, `any_event`=1.
- `clear[1]` asserted on the same edge a new `pulse[1]` fires → `event_sticky[1]` remains 1; clear alone next cycle → 0.
- Channels 0 and 3 rise on the same cycle, mode=11 → both `pulse` bits high in the same single cycle.
- `rst` asserted while channel 2 is in ARM_LOW → no `fall` emitted, all outputs 0 next cycle.
